// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    // Counter width for a given operand width (at least one bit).
    function automatic int unsigned cnt_bits(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_bits(MULDIV_WIDTH);

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIXUP
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath on the {hi,lo} accumulator.
// Multiply: {P,M} add-then-shift-right. Divide: {R,Q} shift-left, restoring trial subtract.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;

    // Compute both iteration flavours and select by operation type
    always_comb begin
        sum       = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shifted   = {acc_hi, acc_lo[WIDTH-1]};
        no_borrow = (shifted >= {1'b0, opnd});
        // Only used when no borrow, so the true difference is below the divisor and fits
        diff      = shifted[WIDTH-1:0] - opnd;
        if (is_div) begin
            nxt_hi = no_borrow ? diff : shifted[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], no_borrow};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_controller.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with a combinational core stall.
// Optional build macro MULDIV_EARLY_EXIT_EN: multiplies finish as soon as the remaining
// multiplier bits are zero.
module muldiv_controller
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mfhi,
    input  logic             mflo,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int unsigned CW = cnt_bits(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             sign_q, sign_d;
    logic             rsign_q, rsign_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    op_e              op_v;
    logic             op_is_div;
    logic             op_signed;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] aligned;
    logic             early_done;
    logic             last_iter;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .acc_hi (acc_hi_q),
        .acc_lo (acc_lo_q),
        .opnd   (opnd_q),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    // Decode the request and form operand magnitudes
    always_comb begin
        op_v      = op_e'(op);
        op_is_div = (op_v == OP_DIVU) || (op_v == OP_DIV);
        op_signed = (op_v == OP_MULT) || (op_v == OP_DIV);
        neg_a     = op_signed & srca[WIDTH-1];
        neg_b     = op_signed & srcb[WIDTH-1];
        a_mag     = neg_a ? -srca : srca;
        b_mag     = neg_b ? -srcb : srcb;
        last_iter = (cnt_q == CW'(WIDTH - 1));
    end

`ifdef MULDIV_EARLY_EXIT_EN
    logic [CW-1:0]      rem_cnt;
    logic [2*WIDTH-1:0] step_acc;

    // Detect an exhausted multiplier; the low rem_cnt bits of M are still unconsumed
    // multiplier bits, and the skipped iterations reduce to a plain right shift.
    always_comb begin
        rem_cnt    = CW'(WIDTH - 1) - cnt_q;
        step_acc   = {step_hi, step_lo};
        early_done = !is_div_q && ((step_lo << (WIDTH - int'(rem_cnt))) == '0);
        aligned    = early_done ? (step_acc >> rem_cnt) : step_acc;
    end
`else
    // Fixed-length iteration: accumulator always takes the plain step result
    always_comb begin
        early_done = 1'b0;
        aligned    = {step_hi, step_lo};
    end
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (op_is_div && (srcb == '0)) ? S_FIXUP : S_RUN;
            S_RUN:   if (last_iter || early_done) state_d = S_FIXUP;
            S_FIXUP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sign-corrected results for the FIXUP write
    always_comb begin
        prod_s = sign_q  ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        quo_s  = sign_q  ? -acc_lo_q : acc_lo_q;
        rem_s  = rsign_q ? -acc_hi_q : acc_hi_q;
    end

    // Datapath next values: operand latch, iteration, HI/LO write
    always_comb begin
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        sign_d     = sign_q;
        rsign_d    = rsign_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    is_div_d   = op_is_div;
                    sign_d     = neg_a ^ neg_b;
                    rsign_d    = neg_a;
                    if (op_is_div) begin
                        if (srcb == '0) begin
                            // Preload the architectural divide-by-zero result; FIXUP copies it as is
                            div_zero_d = 1'b1;
                            acc_hi_d   = srca;
                            acc_lo_d   = '1;
                        end else begin
                            acc_hi_d = '0;
                            acc_lo_d = a_mag;
                            opnd_d   = b_mag;
                        end
                    end else begin
                        acc_hi_d = '0;
                        acc_lo_d = b_mag;
                        opnd_d   = a_mag;
                    end
                end
            end
            S_RUN: begin
                cnt_d    = cnt_q + CW'(1);
                acc_hi_d = aligned[2*WIDTH-1:WIDTH];
                acc_lo_d = aligned[WIDTH-1:0];
            end
            S_FIXUP: begin
                if (div_zero_q) begin
                    hi_d = acc_hi_q;
                    lo_d = acc_lo_q;
                end else if (is_div_q) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            sign_q     <= 1'b0;
            rsign_q    <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            sign_q     <= sign_d;
            rsign_q    <= rsign_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Outputs: stall is a pure combinational function of busy and the core's requests
    always_comb begin
        busy     = (state_q != S_IDLE);
        stall    = busy & (start | mfhi | mflo);
        result   = mfhi ? hi_q : lo_q;
        hi       = hi_q;
        lo       = lo_q;
        div_zero = div_zero_q;
    end

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed self-checking bench for muldiv_controller.
module tb_muldiv_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        mfhi;
    logic        mflo;
    logic        busy;
    logic        stall;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    muldiv_controller #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .srca     (srca),
        .srcb     (srcb),
        .mfhi     (mfhi),
        .mflo     (mflo),
        .busy     (busy),
        .stall    (stall),
        .result   (result),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Issue one op and wait for busy to fall; cyc = number of negedges with busy high
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        @(negedge clk);
        op = o; srca = a; srcb = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        total++;
        if (cyc >= 200) begin bad++; $display("FAIL op_timeout got=%0d want<200", cyc); end
    endtask

    task automatic test_reset();
        int cyc;
        reset = 1'b0; start = 1'b0; op = 2'b00; srca = '0; srcb = '0; mfhi = 1'b0; mflo = 1'b0;
        #12;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL rst_hi got=%h want=0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL rst_lo got=%h want=0", lo); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL rst_dz got=%b want=0", div_zero); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", stall); end
        @(negedge clk); reset = 1'b1;
        run_op(2'b00, 32'd3, 32'd5, cyc);
        total++; if (lo !== 32'd15) begin bad++; $display("FAIL pre_lo got=%h want=%h", lo, 32'd15); end
        // Start the big multiply and kill it mid-RUN
        @(negedge clk);
        op = 2'b00; srca = 32'hFFFFFFFF; srcb = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrun_busy got=%b want=1", busy); end
        #2 reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_rst_busy got=%b want=0", busy); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL async_rst_hi got=%h want=0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL async_rst_lo got=%h want=0", lo); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b want=0", busy); end
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        total++; if (cyc !== 33) begin bad++; $display("FAIL multu_busy_cycles got=%0d want=33", cyc); end
        total++; if (hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_max_hi got=%h want=fffffffe", hi); end
        total++; if (lo !== 32'h00000001) begin bad++; $display("FAIL multu_max_lo got=%h want=00000001", lo); end
    endtask

    task automatic test_mult();
        int cyc;
        run_op(2'b01, 32'hFFFFFFFD, 32'd7, cyc);
        total++; if (cyc !== 33) begin bad++; $display("FAIL mult_busy_cycles got=%0d want=33", cyc); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_neg_hi got=%h want=ffffffff", hi); end
        total++; if (lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_neg_lo got=%h want=ffffffeb", lo); end
        mflo = 1'b1; #1;
        total++; if (result !== 32'hFFFFFFEB) begin bad++; $display("FAIL mflo_result got=%h want=ffffffeb", result); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mflo_stall got=%b want=0", stall); end
        mfhi = 1'b1; #1;
        total++; if (result !== 32'hFFFFFFFF) begin bad++; $display("FAIL mfhi_wins got=%h want=ffffffff", result); end
        mflo = 1'b0; mfhi = 1'b0;
        run_op(2'b01, 32'hFFFFFFFD, 32'hFFFFFFF9, cyc);
        total++; if ({hi, lo} !== 64'd21) begin bad++; $display("FAIL mult_negneg got=%h want=%h", {hi, lo}, 64'd21); end
        run_op(2'b01, 32'h7FFFFFFF, 32'h80000000, cyc);
        total++; if ({hi, lo} !== 64'hC000000080000000) begin bad++; $display("FAIL mult_extreme got=%h want=c000000080000000", {hi, lo}); end
    endtask

    task automatic test_div();
        int cyc;
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, cyc);
        total++; if (cyc !== 33) begin bad++; $display("FAIL div_busy_cycles got=%0d want=33", cyc); end
        total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg_lo got=%h want=fffffffd", lo); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg_hi got=%h want=ffffffff", hi); end
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, cyc);
        total++; if ({hi, lo} !== 64'h8000000000000000) begin bad++; $display("FAIL divu_big got=%h want=8000000000000000", {hi, lo}); end
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, cyc);
        total++; if ({hi, lo} !== 64'h0000000080000000) begin bad++; $display("FAIL div_overflow got=%h want=0000000080000000", {hi, lo}); end
        run_op(2'b10, 32'd100, 32'd7, cyc);
        total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_100_7 got=%h want=%h", {hi, lo}, {32'd2, 32'd14}); end
        run_op(2'b11, 32'd7, 32'hFFFFFFFE, cyc);
        total++; if ({hi, lo} !== {32'd1, 32'hFFFFFFFD}) begin bad++; $display("FAIL div_pos_neg got=%h want=00000001fffffffd", {hi, lo}); end
    endtask

    task automatic test_div_zero();
        int cyc;
        run_op(2'b11, 32'd5, 32'd0, cyc);
        total++; if (cyc !== 1) begin bad++; $display("FAIL dz_busy_cycles got=%0d want=1", cyc); end
        total++; if (hi !== 32'd5) begin bad++; $display("FAIL dz_hi got=%h want=5", hi); end
        total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL dz_lo got=%h want=ffffffff", lo); end
        total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", div_zero); end
        @(negedge clk);
        op = 2'b10; srca = 32'd9; srcb = 32'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear got=%b want=0", div_zero); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL dz_next_busy got=%b want=1", busy); end
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
        total++; if ({hi, lo} !== {32'd0, 32'd3}) begin bad++; $display("FAIL divu_9_3 got=%h want=%h", {hi, lo}, {32'd0, 32'd3}); end
        run_op(2'b11, 32'hFFFFFFFB, 32'd0, cyc);
        total++; if ({hi, lo} !== {32'hFFFFFFFB, 32'hFFFFFFFF}) begin bad++; $display("FAIL dz_signed got=%h want=fffffffbffffffff", {hi, lo}); end
    endtask

    task automatic test_stall_mfhi();
        int cyc;
        int stall_err;
        int hi_err;
        int pre_hi;
        run_op(2'b10, 32'd9, 32'd3, cyc);
        pre_hi = 0;
        stall_err = 0; hi_err = 0;
        @(negedge clk);
        op = 2'b00; srca = 32'h00010000; srcb = 32'h00010000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        repeat (9) begin @(negedge clk); cyc++; end
        mfhi = 1'b1; #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mfhi_stall_c10 got=%b want=1", stall); end
        // A second request while busy must be ignored
        start = 1'b1; op = 2'b10; srca = 32'd1; srcb = 32'd1;
        while (busy === 1'b1 && cyc < 200) begin
            if (stall !== 1'b1) stall_err++;
            if (hi !== 32'(pre_hi)) hi_err++;
            @(negedge clk);
            cyc++;
            if (cyc == 13) start = 1'b0;
        end
        // cyc has stepped one past the last busy negedge
        total++; if (cyc !== 34) begin bad++; $display("FAIL stall_run_len got=%0d want=34", cyc); end
        total++; if (stall_err !== 0) begin bad++; $display("FAIL stall_held got=%0d want=0 drops", stall_err); end
        total++; if (hi_err !== 0) begin bad++; $display("FAIL hi_stable_run got=%0d want=0 changes", hi_err); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_release got=%b want=0", stall); end
        total++; if (result !== 32'd1) begin bad++; $display("FAIL mfhi_new_hi got=%h want=1", result); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL mid_start_lo got=%h want=0", lo); end
        // start together with mfhi in IDLE: read old HI, new op begins
        mfhi = 1'b1; start = 1'b1; op = 2'b00; srca = 32'd2; srcb = 32'd3;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL idle_start_stall got=%b want=0", stall); end
        total++; if (result !== 32'd1) begin bad++; $display("FAIL idle_mfhi_old got=%h want=1", result); end
        @(negedge clk); start = 1'b0; mfhi = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL idle_start_busy got=%b want=1", busy); end
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
        total++; if ({hi, lo} !== 64'd6) begin bad++; $display("FAIL idle_start_prod got=%h want=6", {hi, lo}); end
    endtask

    task automatic test_early_exit();
        int cyc;
        int exp_one;
        int exp_six;
`ifdef MULDIV_EARLY_EXIT_EN
        exp_one = 2;
        exp_six = 4;
`else
        exp_one = 33;
        exp_six = 33;
`endif
        run_op(2'b00, 32'd9, 32'd1, cyc);
        total++; if (cyc !== exp_one) begin bad++; $display("FAIL early_9x1_cycles got=%0d want=%0d", cyc, exp_one); end
        total++; if ({hi, lo} !== 64'd9) begin bad++; $display("FAIL early_9x1 got=%h want=9", {hi, lo}); end
        run_op(2'b00, 32'd3, 32'd6, cyc);
        total++; if (cyc !== exp_six) begin bad++; $display("FAIL early_3x6_cycles got=%0d want=%0d", cyc, exp_six); end
        total++; if ({hi, lo} !== 64'd18) begin bad++; $display("FAIL early_3x6 got=%h want=18", {hi, lo}); end
        run_op(2'b00, 32'hDEADBEEF, 32'd0, cyc);
        total++; if (cyc !== exp_one) begin bad++; $display("FAIL early_x0_cycles got=%0d want=%0d", cyc, exp_one); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL early_x0 got=%h want=0", {hi, lo}); end
        run_op(2'b01, 32'hFFFFFFFF, 32'd1, cyc);
        total++; if ({hi, lo} !== 64'hFFFFFFFFFFFFFFFF) begin bad++; $display("FAIL early_neg1 got=%h want=ffffffffffffffff", {hi, lo}); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_stall_mfhi();
        test_early_exit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
